axis_result_packetizer: RTL and testbench

- Outbound AXI-Stream transmitter for the transpose-convolution result path.
- Accepts a six-word header plus an optional BRAM-dump request from the output manager FSM, and serializes them onto a master AXI-Stream port with full backpressure support.
- Reads result BRAM banks in bank-major order for the data phase and pulses `read_done` back to the manager when the packet has fully left.

---
 rtl/axis_result_packetizer_pkg.sv | 14 +
 rtl/axis_result_packetizer_fifo2.sv | 28 ++
 rtl/axis_result_packetizer.sv | 120 ++++++++++++
 tb/tb_axis_result_packetizer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_result_packetizer_pkg.sv
// axis_result_packetizer_pkg: shared constants and FSM encoding for the result packetizer
package axis_result_packetizer_pkg;
  localparam logic [15:0] HDR_MAGIC_NOTIFY = 16'hC0DE;
  localparam logic [15:0] HDR_MAGIC_DATA = 16'hDA7A;
  localparam logic [15:0] PKT_TYPE_NOTIFY = 16'd1;
  localparam logic [15:0] PKT_TYPE_DATA = 16'd2;
  localparam int NUM_BANKS = 8;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_DONE = 3'd4;
endpackage

// File: rtl/axis_result_packetizer_fifo2.sv
// axis_skid_fifo2: two-entry FIFO whose head word is always presented straight from a register
module axis_skid_fifo2 #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic          valid,
  output logic [DW-1:0] data
);
  logic [DW-1:0] q1;
  assign valid = count != 2'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      data <= '0;
      q1 <= '0;
    end else begin
      if (pop) data <= (count == 2'd2) ? q1 : push_data;
      else if (push && count == 2'd0) data <= push_data;
      if (push && (pop ? count == 2'd2 : count == 2'd1)) q1 <= push_data;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/axis_result_packetizer.sv
// axis_result_packetizer: serializes a six-word header plus an optional bank-major BRAM dump
// onto a master AXI-Stream port with full backpressure
module axis_result_packetizer
  import axis_result_packetizer_pkg::*;
#(
  parameter int DW = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_header,
  input  logic [15:0]       header_word_0,
  input  logic [15:0]       header_word_1,
  input  logic [15:0]       header_word_2,
  input  logic [15:0]       header_word_3,
  input  logic [15:0]       header_word_4,
  input  logic [15:0]       header_word_5,
  input  logic              trigger_read,
  input  logic [2:0]        rd_bram_start,
  input  logic [2:0]        rd_bram_end,
  input  logic [15:0]       rd_addr_count,
  output logic              bram_rd_en,
  output logic [2:0]        bram_rd_sel,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [DW-1:0]     bram_rd_data,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              read_done,
  output logic              busy,
  output logic              req_overrun
);
  state_t state;
  logic [15:0] hdr [6];
  logic [2:0] idx, bank, bank_end;
  logic [15:0] addr, addr_last;
  logic [19:0] words_left, total;
  logic [3:0] nbanks;
  logic data_en, rd_pending, in_hdr, in_stream, hs, pop, last_rd, fifo_valid;
  logic [1:0] fifo_cnt;
  logic [DW-1:0] fifo_data;
  axis_skid_fifo2 #(.DW(DW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(rd_pending),
    .push_data(bram_rd_data),
    .pop(pop),
    .count(fifo_cnt),
    .valid(fifo_valid),
    .data(fifo_data)
  );
  assign in_hdr = state == S_HDR;
  assign in_stream = (state == S_DATA) || (state == S_DRAIN);
  assign m_axis_tvalid = in_hdr || (in_stream && fifo_valid);
  assign m_axis_tdata = in_hdr ? DW'(hdr[idx]) : in_stream ? fifo_data : '0;
  assign m_axis_tlast = in_hdr ? (idx == 3'd5 && !data_en) : (in_stream && fifo_valid && words_left == 20'd1);
  assign hs = m_axis_tvalid && m_axis_tready;
  assign pop = in_stream && hs;
  // buffered plus in-flight words, net of this cycle's pop, must leave room for one more read
  assign bram_rd_en = (state == S_DATA) && ((fifo_cnt + {1'b0, rd_pending}) < (2'd2 + {1'b0, pop}));
  assign bram_rd_sel = bram_rd_en ? bank : 3'd0;
  assign bram_rd_addr = bram_rd_en ? ADDR_W'(addr) : '0;
  assign last_rd = (bank == bank_end) && (addr == addr_last);
  assign read_done = state == S_DONE;
  assign busy = state != S_IDLE;
  assign nbanks = {1'b0, rd_bram_end} - {1'b0, rd_bram_start} + 4'd1;
  assign total = 20'(nbanks) * 20'(rd_addr_count);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int i = 0; i < 6; i++) hdr[i] <= '0;
      idx <= '0;
      bank <= '0;
      bank_end <= '0;
      addr <= '0;
      addr_last <= '0;
      words_left <= '0;
      data_en <= 1'b0;
      rd_pending <= 1'b0;
      req_overrun <= 1'b0;
    end else begin
      rd_pending <= bram_rd_en;
      if (send_header && busy) req_overrun <= 1'b1;
      if (pop) words_left <= words_left - 20'd1;
      case (state)
        S_IDLE: if (send_header) begin
          hdr[0] <= header_word_0;
          hdr[1] <= header_word_1;
          hdr[2] <= header_word_2;
          hdr[3] <= header_word_3;
          hdr[4] <= header_word_4;
          hdr[5] <= header_word_5;
          idx <= '0;
          data_en <= trigger_read && rd_addr_count != 16'd0 && rd_bram_start <= rd_bram_end;
          bank <= rd_bram_start;
          bank_end <= rd_bram_end;
          addr <= '0;
          addr_last <= rd_addr_count - 16'd1;
          words_left <= total;
          state <= S_HDR;
        end
        S_HDR: if (hs) begin
          idx <= idx + 3'd1;
          if (idx == 3'd5) state <= data_en ? S_DATA : S_DONE;
        end
        // the final-read compare precedes any bank increment, so end = 7 never wraps
        S_DATA: if (bram_rd_en) begin
          if (last_rd) state <= S_DRAIN;
          else if (addr == addr_last) begin
            bank <= bank + 3'd1;
            addr <= '0;
          end else addr <= addr + 16'd1;
        end
        S_DRAIN: if (pop && words_left == 20'd1) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_result_packetizer.sv
// tb_axis_result_packetizer: vector table plus reference model for the result packetizer
module tb_axis_result_packetizer;
  typedef struct packed {logic [15:0] d; logic l;} beat_t;
  typedef struct packed {
    logic [5:0][15:0] w;
    logic trig;
    logic [2:0] s;
    logic [2:0] e;
    logic [15:0] cnt;
    int rdy;
    int beats;
  } vec_t;
  logic clk = 0, rst_n = 0, send_header = 0, trigger_read = 0, m_axis_tready = 0;
  logic [15:0] header_word_0 = 0, header_word_1 = 0, header_word_2 = 0;
  logic [15:0] header_word_3 = 0, header_word_4 = 0, header_word_5 = 0;
  logic [2:0] rd_bram_start = 0, rd_bram_end = 0;
  logic [15:0] rd_addr_count = 0, bram_rd_data = 0;
  logic bram_rd_en, m_axis_tvalid, m_axis_tlast, read_done, busy, req_overrun;
  logic [2:0] bram_rd_sel;
  logic [15:0] bram_rd_addr, m_axis_tdata;
  beat_t got[$], expq[$], bt;
  vec_t vecs[8];
  int checks = 0, errors = 0, ready_pct = 100;
  int done_cnt = 0, rd_cnt = 0, pops = 0, cyc = 0, send_cyc = 0, done_cyc = 0, last_cyc = 0;
  logic pv = 0, pr = 0, pl = 0;
  logic [15:0] pd = 0;
  axis_result_packetizer #(.DW(16), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .send_header(send_header),
    .header_word_0(header_word_0), .header_word_1(header_word_1), .header_word_2(header_word_2),
    .header_word_3(header_word_3), .header_word_4(header_word_4), .header_word_5(header_word_5),
    .trigger_read(trigger_read), .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
    .rd_addr_count(rd_addr_count), .bram_rd_en(bram_rd_en), .bram_rd_sel(bram_rd_sel),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .read_done(read_done), .busy(busy), .req_overrun(req_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_rd_en) bram_rd_data <= {bram_rd_sel, bram_rd_addr[12:0]};
  always @(posedge clk) begin
    #1;
    m_axis_tready = ($urandom_range(0, 99) < ready_pct);
  end
  always @(negedge clk) begin
    if (!rst_n) pv = 0;
    else begin
      if (pv && !pr) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
          errors++;
          $display("FAIL axi_stable: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
        end
      end
      if (bram_rd_en) rd_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        bt.d = m_axis_tdata;
        bt.l = m_axis_tlast;
        got.push_back(bt);
        last_cyc = cyc;
        if (rd_cnt > pops) pops++;
      end
      if (bram_rd_en) begin
        checks++;
        if (rd_cnt - pops > 2) begin
          errors++;
          $display("FAIL buffered_words: got %0d outstanding, need <= 2", rd_cnt - pops);
        end
      end
      if (read_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (send_header && !busy) send_cyc = cyc;
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [95:0] ws, input logic trig, input logic [2:0] s, input logic [2:0] e,
                              input logic [15:0] cnt, input int rdy, input int beats);
    vec_t v;
    v.w = ws;
    v.trig = trig;
    v.s = s;
    v.e = e;
    v.cnt = cnt;
    v.rdy = rdy;
    v.beats = beats;
    return v;
  endfunction
  task automatic add_model(input vec_t v);
    beat_t b;
    for (int i = 0; i < 6; i++) begin
      b.d = v.w[i];
      b.l = 0;
      expq.push_back(b);
    end
    if (v.trig && v.cnt != 0 && v.s <= v.e)
      for (int k = int'(v.s); k <= int'(v.e); k++)
        for (int a = 0; a < int'(v.cnt); a++) begin
          b.d = {k[2:0], a[12:0]};
          b.l = 0;
          expq.push_back(b);
        end
    expq[expq.size() - 1].l = 1;
  endtask
  task automatic clear();
    got.delete();
    expq.delete();
    done_cnt = 0;
    rd_cnt = 0;
    pops = 0;
  endtask
  task automatic send(input vec_t v);
    @(posedge clk); #1;
    header_word_0 = v.w[0];
    header_word_1 = v.w[1];
    header_word_2 = v.w[2];
    header_word_3 = v.w[3];
    header_word_4 = v.w[4];
    header_word_5 = v.w[5];
    trigger_read = v.trig;
    rd_bram_start = v.s;
    rd_bram_end = v.e;
    rd_addr_count = v.cnt;
    send_header = 1;
    @(posedge clk); #1;
    send_header = 0;
  endtask
  task automatic wait_done(input string nm, input int n);
    int to = 0;
    while (done_cnt < n && to < 30000) begin
      @(posedge clk);
      to++;
    end
    chk({nm, "_done_in_time"}, 32'(done_cnt >= n), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic cmp_seq(input string nm);
    int bad = 0, first = -1;
    chk({nm, "_beats"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    chk({nm, "_seq_diffs"}, bad, 0);
    if (first >= 0)
      $display("  %s first differing beat %0d: got %h/%0b expected %h/%0b", nm, first,
               got[first].d, got[first].l, expq[first].d, expq[first].l);
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    clear();
    add_model(v);
    ready_pct = v.rdy;
    send(v);
    chk({nm, "_hdr_start_valid"}, m_axis_tvalid, 1);
    chk({nm, "_hdr_start_data"}, m_axis_tdata, v.w[0]);
    wait_done(nm, 1);
    cmp_seq(nm);
    chk({nm, "_beats_table"}, got.size(), v.beats);
    chk({nm, "_read_done_pulses"}, done_cnt, 1);
    chk({nm, "_bram_reads"}, rd_cnt, expq.size() - 6);
    chk({nm, "_done_after_last"}, done_cyc - last_cyc, 1);
    if (v.rdy == 100)
      chk({nm, "_latency"}, done_cyc - send_cyc, (expq.size() == 6) ? 7 : expq.size() - 6 + 9);
    chk({nm, "_idle_after"}, busy, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int to, c;
    vec_t vo, vb, vc, vr;
    logic [95:0] hn, hd;
    hn = {16'h0000, 16'h000B, 16'h0008, 16'h0002, 16'h0001, 16'hC0DE};
    hd = {16'h0000, 16'h0200, 16'h0007, 16'h0000, 16'h0002, 16'hDA7A};
    c = $urandom_range(1, 20);
    vecs[0] = mk(hn, 0, 0, 0, 16'd0, 100, 6);
    vecs[1] = mk(hd, 1, 0, 7, 16'd512, 100, 4102);
    vecs[2] = mk(hd, 1, 0, 7, 16'd512, 50, 4102);
    vecs[3] = mk(hd, 1, 5, 5, 16'd1, 100, 7);
    vecs[4] = mk(hd, 1, 2, 4, 16'd0, 100, 6);
    vecs[5] = mk(hd, 1, 3, 2, 16'd4, 100, 6);
    vecs[6] = mk(hd, 1, 1, 3, 16'(c), 50, 6 + 3 * c);
    vecs[7] = mk(hd, 1, 7, 7, 16'd3, 70, 9);
    ready_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_rd_en", bram_rd_en, 0);
    chk("rst_read_done", read_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", req_overrun, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    vo = mk(hd, 1, 0, 1, 16'd50, 100, 106);
    vb = mk({6{16'hBAD0}}, 1, 2, 2, 16'd5, 100, 0);
    vc = mk(hn, 1, 6, 7, 16'd3, 100, 12);
    clear();
    add_model(vo);
    add_model(vc);
    ready_pct = 100;
    chk("ovr_flag_before", req_overrun, 0);
    send(vo);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_busy_mid", busy, 1);
    send(vb);
    chk("ovr_flag_set", req_overrun, 1);
    to = 0;
    while (!read_done && to < 2000) begin
      @(posedge clk); #1;
      to++;
    end
    chk("ovr_first_done", read_done, 1);
    send(vc);
    chk("b2b_accepted", busy, 1);
    wait_done("b2b", 2);
    cmp_seq("ovr_b2b");
    chk("ovr_b2b_done_pulses", done_cnt, 2);
    chk("ovr_b2b_reads", rd_cnt, 106);
    chk("ovr_flag_sticky", req_overrun, 1);
    clear();
    vr = mk(hd, 1, 0, 7, 16'd512, 100, 4102);
    send(vr);
    to = 0;
    while (got.size() < 100 && to < 2000) begin
      @(posedge clk); #1;
      to++;
    end
    chk("rstmid_reached_beat100", 32'(got.size() >= 100), 1);
    rst_n = 0;
    #1;
    chk("rstmid_tvalid", m_axis_tvalid, 0);
    chk("rstmid_tlast", m_axis_tlast, 0);
    chk("rstmid_tdata", m_axis_tdata, 0);
    chk("rstmid_rd_en", bram_rd_en, 0);
    chk("rstmid_rd_sel", bram_rd_sel, 0);
    chk("rstmid_rd_addr", bram_rd_addr, 0);
    chk("rstmid_read_done", read_done, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_overrun", req_overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_idle_tvalid", m_axis_tvalid, 0);
    run_vec(vecs[3], "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
